// File: rtl/upsampler_coef_ctrl.sv
// upsampler_coef_ctrl: run-time coefficient loader/sequencer for the
// upsampler chain (half-band + CIC compensator). Freezes the chain enable
// while coefficients are written, steers writes, then flushes the chain.
//
// Ports:
//   clk, reset (async, active-high)
//   ce_in            raw chain enable from the rate source
//   cfg_start/cfg_sel/cfg_we/cfg_addr/cfg_data/cfg_commit  CSR side
//   chain_ce/chain_hold/chain_flush                        chain control
//   hb_coef_we/addr/data, comp_coef_we/addr/data           coefficient ports
//   busy, done, err                                        status
//
// Optional feature macro: UPS_COEF_CHECKSUM_EN adds cfg_csum (32-bit
// running sum of sign-extended accepted coefficients).
module upsampler_coef_ctrl #(
    parameter int HB_CW        = 19,
    parameter int HB_DEPTH     = 64,
    parameter int COMP_CW      = 16,
    parameter int COMP_DEPTH   = 32,
    parameter int AW           = 6,
    parameter int FLUSH_CYCLES = 16,
    parameter int LOAD_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_in,
    input  logic                cfg_start,
    input  logic                cfg_sel,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [31:0]         cfg_data,
    input  logic                cfg_commit,
    output logic                chain_ce,
    output logic                chain_hold,
    output logic                chain_flush,
    output logic                hb_coef_we,
    output logic [AW-1:0]       hb_coef_addr,
    output logic [HB_CW-1:0]    hb_coef_data,
    output logic                comp_coef_we,
    output logic [AW-1:0]       comp_coef_addr,
    output logic [COMP_CW-1:0]  comp_coef_data,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef UPS_COEF_CHECKSUM_EN
    ,
    output logic [31:0]         cfg_csum
`endif
);

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOAD,
        FLUSH,
        RESUME
    } state_t;

    state_t          state;
    logic [TW-1:0]   idle_cnt;
    logic [FW-1:0]   flush_cnt;
    logic            hb_ok;
    logic            comp_ok;
    logic            timeout;

    // Address range checks widened by one bit so DEPTH == 2^AW fits.
    assign hb_ok   = {1'b0, cfg_addr} < (AW+1)'(HB_DEPTH);
    assign comp_ok = {1'b0, cfg_addr} < (AW+1)'(COMP_DEPTH);

    // A cycle with a write or commit is never an idle cycle.
    assign timeout = !cfg_we && !cfg_commit &&
                     (idle_cnt == TW'(LOAD_TIMEOUT - 1));

    // Reset is folded in so the gated enable is 0 while reset is held.
    assign chain_ce = ce_in & ~chain_hold & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idle_cnt       <= '0;
            flush_cnt      <= '0;
            chain_hold     <= 1'b0;
            chain_flush    <= 1'b0;
            hb_coef_we     <= 1'b0;
            hb_coef_addr   <= '0;
            hb_coef_data   <= '0;
            comp_coef_we   <= 1'b0;
            comp_coef_addr <= '0;
            comp_coef_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
`ifdef UPS_COEF_CHECKSUM_EN
            cfg_csum       <= '0;
`endif
        end else begin
            done         <= 1'b0;
            hb_coef_we   <= 1'b0;
            comp_coef_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state      <= HOLD;
                        chain_hold <= 1'b1;
                        busy       <= 1'b1;
                        err        <= 1'b0;
`ifdef UPS_COEF_CHECKSUM_EN
                        cfg_csum   <= '0;
`endif
                    end
                end
                HOLD: begin
                    // Never cut an enable that is already asserted.
                    if (!ce_in) begin
                        state    <= LOAD;
                        idle_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_we) begin
                        idle_cnt <= '0;
                        if (!cfg_sel) begin
                            if (hb_ok) begin
                                hb_coef_we   <= 1'b1;
                                hb_coef_addr <= cfg_addr;
                                hb_coef_data <= cfg_data[HB_CW-1:0];
`ifdef UPS_COEF_CHECKSUM_EN
                                cfg_csum <= cfg_csum +
                                    {{(32-HB_CW){cfg_data[HB_CW-1]}},
                                     cfg_data[HB_CW-1:0]};
`endif
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            if (comp_ok) begin
                                comp_coef_we   <= 1'b1;
                                comp_coef_addr <= cfg_addr;
                                comp_coef_data <= cfg_data[COMP_CW-1:0];
`ifdef UPS_COEF_CHECKSUM_EN
                                cfg_csum <= cfg_csum +
                                    {{(32-COMP_CW){cfg_data[COMP_CW-1]}},
                                     cfg_data[COMP_CW-1:0]};
`endif
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else if (!cfg_commit) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // A same-cycle write is captured above before closing.
                    if (cfg_commit || timeout) begin
                        state       <= FLUSH;
                        chain_flush <= 1'b1;
                        flush_cnt   <= FW'(FLUSH_CYCLES - 1);
                    end
                    if (timeout) begin
                        err <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state       <= RESUME;
                        chain_flush <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                RESUME: begin
                    state      <= IDLE;
                    chain_hold <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Stray writes outside a load window are flagged.
            if (cfg_we && state != LOAD) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/upsampler_coef_ctrl.md
# upsampler_coef_ctrl

Run-time coefficient loader and sequencer for the upsampler interpolation chain: the half-band stage (19-bit, 64-entry) and the CIC-compensation stage (16-bit, 32-entry). It takes CSR-side coefficient writes from the SoC. It freezes the chain's clock-enable while coefficients change, steers each write to the selected filter's coefficient port, and flushes the chain's delay lines before resuming. It sits between the LiteX CSR bank and the upsamplerFilter chain's `clk_enable` and coefficient-RAM write ports.

## Interface
Clock: single clock `clk`. Reset: `reset`, asynchronous, active-high.

**Parameters**
- `HB_CW` = 19: half-band coefficient width.
- `HB_DEPTH` = 64: half-band coefficient entries.
- `COMP_CW` = 16: compensator coefficient width.
- `COMP_DEPTH` = 32: compensator coefficient entries.
- `AW` = 6: address width, sized so that 2^AW ≥ max(HB_DEPTH, COMP_DEPTH).
- `FLUSH_CYCLES` = 16: length of the `chain_flush` pulse; must be ≥ 1.
- `LOAD_TIMEOUT` = 65535: number of LOAD cycles with no write or commit before the block auto-aborts.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ce_in` in 1: raw chain clock-enable from the rate source.
- `cfg_start` in 1: single-cycle pulse that opens a load session.
- `cfg_sel` in 1: target filter, 0 = half-band, 1 = compensator.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_addr` in AW: coefficient index.
- `cfg_data` in 32: coefficient value; only the low CW bits are used.
- `cfg_commit` in 1: single-cycle pulse that closes the session.
- `chain_ce` out 1: gated enable to the chain, equal to `ce_in & ~chain_hold`.
- `chain_hold` out 1: chain frozen.
- `chain_flush` out 1: synchronous clear to the chain's delay lines.
- `hb_coef_we` out 1; `hb_coef_addr` out AW; `hb_coef_data` out HB_CW.
- `comp_coef_we` out 1; `comp_coef_addr` out AW; `comp_coef_data` out COMP_CW.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse when a session completes.
- `err` out 1: sticky error; cleared by the next accepted `cfg_start`.

## Operation
The block is a state machine with five states: IDLE, HOLD, LOAD, FLUSH, RESUME.

- **IDLE**
  - `chain_hold`=0; `chain_ce` follows `ce_in`.
  - `cfg_start` → HOLD. On that edge, `err` is cleared.
- **HOLD**
  - `chain_hold`=1.
  - Waits for the first cycle with `ce_in`=0, so that an enable already in flight is never cut. Then → LOAD.
- **LOAD**
  - `chain_hold`=1.
  - Each `cfg_we` is registered once and then drives the selected port.
    - `cfg_sel`=0: writes `hb_coef_*` with data `cfg_data[HB_CW-1:0]`.
    - `cfg_sel`=1: writes `comp_coef_*` with data `cfg_data[COMP_CW-1:0]`.
  - Address at or above the selected filter's DEPTH: the write is dropped and `err` is set.
  - `cfg_commit` → FLUSH. If `cfg_we` and `cfg_commit` arrive in the same cycle, the write is performed first, then the commit.
  - Idle counter: reset by each `cfg_we`; on reaching LOAD_TIMEOUT, sets `err` and → FLUSH.
- **FLUSH**
  - `chain_hold`=1 and `chain_flush`=1 for exactly FLUSH_CYCLES cycles, then → RESUME.
- **RESUME**
  - Lasts one cycle. `chain_hold` is released, `done`=1, then → IDLE.

Event rules:
- `cfg_start` outside IDLE is ignored.
- `cfg_we` outside LOAD is ignored and sets `err`.
- `cfg_commit` outside LOAD is ignored.
- At most one coefficient `*_we` is high in any cycle. Both are 0 outside the cycle after an accepted write.

## Timing
- Reset values: state=IDLE. All outputs are 0: `chain_hold`, `chain_flush`, both `*_we`, addresses, data, `busy`, `done`, `err`, and `chain_ce`.
- `cfg_start` at cycle t: `chain_hold`=1 and `busy`=1 from t+1.
- HOLD→LOAD takes at least one cycle. It extends while `ce_in` stays 1.
- Write path: `cfg_we` at t produces `*_coef_we` at t+1.
- Commit path:
  - `cfg_commit` at t: `chain_flush` is high over cycles t+1 … t+FLUSH_CYCLES.
  - RESUME and `done` at t+FLUSH_CYCLES+1.
  - `chain_hold`=0 from t+FLUSH_CYCLES+2.
- `chain_ce` is combinational from `ce_in` and registered `chain_hold`.
- Reset mid-session: the block returns to IDLE immediately, all outputs drop to 0, and any pending write is discarded.

## Configuration
- Macro `UPS_COEF_CHECKSUM_EN`.
  - Defined: adds output `cfg_csum` (32 bits). On every accepted write it accumulates the sign-extended written coefficient, with 32-bit wrap-around. It is cleared to 0 on accepted `cfg_start` and on reset, and holds its value after `done`.
  - Undefined: the port and the accumulator are absent. All other behaviour is identical.

## Test plan
1. Reset, then `cfg_start` with `ce_in`=0. Write half-band addr 0 ← 0x0003FFFF and addr 63 ← 0x00012345, then commit with FLUSH_CYCLES=16.
   - Required: `hb_coef_we` pulses with data 0x3FFFF and 0x12345.
   - Required: `chain_flush` is high for 16 cycles, `done` fires once, and `chain_ce` resumes.
2. `cfg_start` while `ce_in`=1 for 3 cycles.
   - Required: the block stays in HOLD for those 3 cycles and no coefficient write occurs before LOAD.
3. Compensator write to addr 32.
   - Required: the write is dropped, `comp_coef_we` stays 0 and `err`=1.
   - Required: the next `cfg_start` clears `err`.
4. `cfg_we` and `cfg_commit` in the same cycle.
   - Required: exactly one write, then FLUSH.
   - Required: `cfg_start` during FLUSH is ignored, and `busy` stays 1 until RESUME.
5. LOAD_TIMEOUT=8 with no writes.
   - Required: the block enters FLUSH after 8 cycles with `err`=1, and `done` still pulses.
6. Assert `reset` in the middle of LOAD.
   - Required: all outputs are 0 in the same cycle and `chain_ce` follows `ce_in` afterwards.
   - With `UPS_COEF_CHECKSUM_EN`: writes 0xFFFF and 0x0002 to the compensator give `cfg_csum`=0x00000001.
